// File: rtl/prog_loader_if.sv
// Program byte stream and CPU memory write port used by prog_loader.
// The slave modport is the loader's view; master is the environment side.
interface prog_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_wr;
  logic [4:0] mem_addr;
  logic [7:0] mem_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_wr, mem_addr, mem_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_wr, mem_addr, mem_data
  );
endinterface

// File: rtl/prog_loader.sv
// Loads a program into CPU memory, releases CPU reset, and watches for halt or timeout.
// Optional LOADER_CHECKSUM_EN: a trailing mod-256 checksum byte gates the CPU release.
module prog_loader #(
  parameter int unsigned PROG_LEN    = 32,
  parameter logic [4:0]  EXPECT_PC   = 5'h17,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  prog_loader_if.slave bus,
  output logic         cpu_rst,
  input  logic         cpu_halt,
  input  logic [4:0]   cpu_pc,
  output logic         done,
  output logic         pass,
  output logic         timeout,
  output logic         csum_err
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] RELEASE = 3'd2;
  localparam logic [2:0] RUN     = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  localparam int unsigned CntW = 6;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     cyc_q, cyc_d;
  logic            rel_q, rel_d;
  logic            pass_q, pass_d;
  logic            timeout_q, timeout_d;
  logic            wr_q, wr_d;
  logic [4:0]      addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic            accept;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]      sum_q, sum_d;
  logic            csum_err_q, csum_err_d;
`endif

  assign accept = bus.in_valid && (state_q == LOAD);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cyc_d     = cyc_q;
    rel_d     = 1'b0;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    wr_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d      = sum_q;
    csum_err_d = csum_err_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = LOAD;
          cnt_d     = '0;
          cyc_d     = '0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          sum_d      = '0;
          csum_err_d = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (accept) begin
`ifdef LOADER_CHECKSUM_EN
          // Byte index PROG_LEN is the checksum: compared, never written.
          if (cnt_q == CntW'(PROG_LEN)) begin
            if (bus.in_data == sum_q) begin
              state_d = RELEASE;
            end else begin
              state_d    = DONE;
              csum_err_d = 1'b1;
            end
          end else begin
            wr_d   = 1'b1;
            addr_d = cnt_q[4:0];
            data_d = bus.in_data;
            cnt_d  = cnt_q + CntW'(1);
            sum_d  = sum_q + bus.in_data;
          end
`else
          wr_d   = 1'b1;
          addr_d = cnt_q[4:0];
          data_d = bus.in_data;
          cnt_d  = cnt_q + CntW'(1);
          if (cnt_q == CntW'(PROG_LEN - 1)) begin
            state_d = RELEASE;
          end
`endif
        end
      end
      RELEASE: begin
        // Two cycles so the final memory write lands while the CPU is still in reset.
        rel_d = 1'b1;
        if (rel_q) begin
          state_d = RUN;
          cyc_d   = '0;
        end
      end
      RUN: begin
        if (cpu_halt) begin
          state_d   = DONE;
          pass_d    = (cpu_pc == EXPECT_PC);
          timeout_d = 1'b0;
        end else if (cyc_q + 16'd1 == 16'(TIMEOUT_CYC)) begin
          state_d   = DONE;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end else begin
          cyc_d = cyc_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cyc_q     <= '0;
      rel_q     <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= '0;
      csum_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cyc_q     <= cyc_d;
      rel_q     <= rel_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
      csum_err_q <= csum_err_d;
`endif
    end
  end

  assign bus.in_ready = (state_q == LOAD);
  assign bus.mem_wr   = wr_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_data = data_q;
  assign done         = (state_q == DONE);
  assign pass         = pass_q;
  assign timeout      = timeout_q;
`ifdef LOADER_CHECKSUM_EN
  assign csum_err = csum_err_q;
`else
  assign csum_err = 1'b0;
`endif
  // A checksum failure parks in DONE with the CPU still held in reset.
  assign cpu_rst = !((state_q == RUN) || ((state_q == DONE) && !csum_err));

endmodule
